weight_loader: RTL and testbench

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/weight_loader.sv | 105 ++++++++++
 tb/tb_weight_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - streams weight bytes into a two-bank weight regfile
module weight_loader #(
  parameter int NUM_WEIGHTS = 50,
  parameter int BANK_SIZE   = 25,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              sel_toggle,
  output logic              weight_select,
  output logic [1:0]        kernel_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WEIGHTS - 1);
  localparam logic [ADDR_W-1:0] BANK_LAST = ADDR_W'(BANK_SIZE - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              xfer;

  // Handshake outputs are pure state decodes, so they never glitch on inputs
  assign s_ready = (state == LOAD);
  assign busy    = s_ready;
  assign done    = (state == DONE);
  assign xfer    = s_valid && s_ready;

  // Sequencer: IDLE -> LOAD on start, LOAD -> DONE on the final byte, DONE -> IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          if (xfer) begin
            // cnt parks on the last address instead of wrapping
            if (cnt == LAST_ADDR) state <= DONE;
            else                  cnt   <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Regfile write port: one registered write per accepted byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= xfer;
      if (xfer) begin
        wr_addr <= cnt;
        wr_data <= s_data;
      end
    end
  end

  // Bank-complete flags rise once the last write of each bank has landed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kernel_ready <= 2'b00;
    end else if (state == IDLE && start) begin
      kernel_ready <= 2'b00;
    end else if (wr_en) begin
      if (wr_addr == BANK_LAST) kernel_ready[0] <= 1'b1;
      if (wr_addr == LAST_ADDR) kernel_ready[1] <= 1'b1;
    end
  end

  // Consumer may only flip to the other bank once that bank is complete
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight_select <= 1'b0;
    end else if (sel_toggle && kernel_ready[~weight_select]) begin
      weight_select <= ~weight_select;
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// tb/tb_weight_loader.sv - directed self-checking bench for weight_loader
module tb_weight_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       sel_toggle = 1'b0;
  logic       s_ready;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       weight_select;
  logic [1:0] kernel_ready;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  weight_loader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .sel_toggle    (sel_toggle),
    .weight_select (weight_select),
    .kernel_ready  (kernel_ready),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_wsel"}, 32'(weight_select), 32'd0);
    chk({tag, "_kready"}, 32'(kernel_ready), 32'd0);
  endtask

  initial begin
    int xfers;
    bit toggled;
    bit exp_xfer;

    // Power-on reset, observed before any clock edge
    #1 rst = 1'b1;
    #1 chk_all_zero("reset0");
    tick();
    rst = 1'b0;
    tick();

    // Load with bubbles; probe a disallowed bank switch while only bank 0 is ready
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("bub_busy", 32'(busy), 32'd1);
    chk("bub_sready", 32'(s_ready), 32'd1);
    chk("bub_kready0", 32'(kernel_ready), 32'd0);
    chk("bub_wr_en0", 32'(wr_en), 32'd0);
    xfers = 0;
    toggled = 1'b0;
    for (int cyc = 0; cyc < 200 && xfers < 50; cyc++) begin
      s_valid = (cyc % 2) == 0;
      s_data = 8'(xfers + 8'h40);
      exp_xfer = s_valid;
      sel_toggle = (xfers == 30) && !toggled;
      tick();
      chk("bub_wr_en", 32'(wr_en), 32'(exp_xfer));
      if (exp_xfer) begin
        chk("bub_addr", 32'(wr_addr), 32'(xfers));
        chk("bub_data", 32'(wr_data), 32'(8'(xfers + 8'h40)));
        chk("bub_done", 32'(done), 32'(xfers == 49));
        xfers++;
      end
      if (sel_toggle) begin
        toggled = 1'b1;
        chk("bub_kready_01", 32'(kernel_ready), 32'd1);
        chk("bub_wsel_stay0", 32'(weight_select), 32'd0);
      end
    end
    sel_toggle = 1'b0;
    s_valid = 1'b0;
    chk("bub_count", 32'(xfers), 32'd50);
    tick();
    chk("bub_kready_11", 32'(kernel_ready), 32'd3);
    chk("bub_idle_busy", 32'(busy), 32'd0);
    chk("bub_idle_wr_en", 32'(wr_en), 32'd0);

    // Back-to-back full load of 0x01..0x32
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("full_kready_clr", 32'(kernel_ready), 32'd0);
    s_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      s_data = 8'(i + 1);
      tick();
      chk("full_wr_en", 32'(wr_en), 32'd1);
      chk("full_addr", 32'(wr_addr), 32'(i));
      chk("full_data", 32'(wr_data), 32'(i + 1));
      chk("full_done", 32'(done), 32'(i == 49));
      if (i == 24) chk("full_kready_a24", 32'(kernel_ready), 32'd0);
      if (i == 25) chk("full_kready_a25", 32'(kernel_ready), 32'd1);
      if (i == 49) chk("full_kready_a49", 32'(kernel_ready), 32'd1);
    end
    s_valid = 1'b0;
    tick();
    chk("full_kready_11", 32'(kernel_ready), 32'd3);
    chk("full_done_low", 32'(done), 32'd0);
    chk("full_wr_en_low", 32'(wr_en), 32'd0);

    // Bank switching with both banks ready
    sel_toggle = 1'b1;
    tick();
    chk("sel_to1", 32'(weight_select), 32'd1);
    tick();
    chk("sel_to0", 32'(weight_select), 32'd0);
    tick();
    sel_toggle = 1'b0;
    chk("sel_to1_again", 32'(weight_select), 32'd1);
    tick();
    chk("sel_hold", 32'(weight_select), 32'd1);

    // Stray starts during LOAD, then an asynchronous abort after 30 transfers
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_wsel_kept", 32'(weight_select), 32'd1);
    s_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      s_data = 8'(i + 8'h90);
      start = (i == 10) || (i == 27);
      tick();
      chk("stray_addr", 32'(wr_addr), 32'(i));
      chk("stray_data", 32'(wr_data), 32'(8'(i + 8'h90)));
    end
    start = 1'b0;
    s_valid = 1'b0;
    chk("stray_busy", 32'(busy), 32'd1);
    chk("stray_kready_01", 32'(kernel_ready), 32'd1);
    #3 rst = 1'b1;
    #1 chk_all_zero("abort");
    #2 rst = 1'b0;
    s_valid = 1'b1;
    tick();
    chk("post_abort_wr_en0", 32'(wr_en), 32'd0);
    tick();
    chk("post_abort_wr_en1", 32'(wr_en), 32'd0);
    chk("post_abort_busy", 32'(busy), 32'd0);

    // Fresh start after abort restarts from address 0
    s_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    s_valid = 1'b1;
    s_data = 8'h77;
    tick();
    s_valid = 1'b0;
    chk("reload_wr_en", 32'(wr_en), 32'd1);
    chk("reload_addr", 32'(wr_addr), 32'd0);
    chk("reload_data", 32'(wr_data), 32'h77);
    s_data = 8'h78;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("reload_addr1", 32'(wr_addr), 32'd1);
    tick();
    chk("reload_gap_wr_en", 32'(wr_en), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
